inst_fetch: RTL and testbench

//   Instruction-fetch stage of the MIPS pipeline. Holds the PC and drives the word

---
 rtl/inst_fetch_pkg.sv | 23 ++
 rtl/inst_fetch_pc_next_sel.sv | 62 ++++++
 rtl/inst_fetch.sv | 83 ++++++++
 tb/tb_inst_fetch.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - fetch-stage vector constants, NOP encoding and next-PC source enum
package inst_fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_HOLD,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_JR,
        SRC_IRQ,
        SRC_EXC
    } pc_src_e;

    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return {3'b000, byte_addr[30:2]};
    endfunction

endpackage

// File: rtl/inst_fetch_pc_next_sel.sv
// rtl/inst_fetch_pc_next_sel.sv - combinational priority mux selecting the next fetch PC
module pc_next_sel
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = DEF_IRQ_VEC,
    parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        irq,
    input  logic        exception,
    input  logic [31:0] exc_pc,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        epc_load,
    output logic [31:0] epc_value
);

    pc_src_e src;

    // Interrupts are masked while executing in kernel space (pc[31] set).
    always_comb begin
        src = SRC_SEQ;
        if (exception)              src = SRC_EXC;
        else if (irq && !pc[31])    src = SRC_IRQ;
        else if (jr)                src = SRC_JR;
        else if (jump)              src = SRC_JUMP;
        else if (branch_taken)      src = SRC_BRANCH;
        else if (stall)             src = SRC_HOLD;
    end

    always_comb begin
        next_pc   = pc + 32'd4;
        epc_load  = 1'b0;
        epc_value = pc;
        case (src)
            SRC_EXC: begin
                next_pc   = EXC_VEC;
                epc_load  = 1'b1;
                epc_value = exc_pc;
            end
            SRC_IRQ: begin
                next_pc   = IRQ_VEC;
                epc_load  = 1'b1;
            end
            SRC_JR:     next_pc = jr_target;
            SRC_JUMP:   next_pc = jump_target;
            SRC_BRANCH: next_pc = branch_target;
            SRC_HOLD:   next_pc = pc;
            default:    next_pc = pc + 32'd4;
        endcase
    end

    assign redirect = (src != SRC_SEQ) && (src != SRC_HOLD);

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - MIPS fetch stage: PC register, ROM addressing and IF/ID register
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] IRQ_VEC   = DEF_IRQ_VEC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        irq,
    input  logic        exception,
    input  logic [31:0] exc_pc,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] epc
);

    logic [31:0] next_pc;
    logic        redirect;
    logic        epc_load;
    logic [31:0] epc_value;

    pc_next_sel #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_pc_next_sel (
        .pc            (pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .irq           (irq),
        .exception     (exception),
        .exc_pc        (exc_pc),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .epc_load      (epc_load),
        .epc_value     (epc_value)
    );

    assign rom_addr = word_index(pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            epc         <= 32'd0;
        end else begin
            pc <= next_pc;
            if (epc_load)
                epc <= epc_value;
            // Bubbles keep the old pc4 so downstream link logic sees a stable value.
            if (redirect || flush) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else if (!stall) begin
                if_id_instr <= rom_data;
                if_id_pc4   <= pc + 32'd4;
                if_id_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized and directed self-checking bench for inst_fetch
module tb_inst_fetch;

    localparam logic [31:0] R_PC  = 32'h8000_0000;
    localparam logic [31:0] I_VEC = 32'h8000_0004;
    localparam logic [31:0] E_VEC = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rom_addr, rom_data;
    logic        stall, flush, branch_taken, jump, jr, irq, exception;
    logic [31:0] branch_target, jump_target, jr_target, exc_pc;
    logic [31:0] pc, if_id_instr, if_id_pc4, epc;
    logic        if_id_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc, m_instr, m_pc4, m_epc;
    logic        m_valid;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] widx);
        return (widx * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    inst_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .irq           (irq),
        .exception     (exception),
        .exc_pc        (exc_pc),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .epc           (epc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; branch_taken = 0; jump = 0; jr = 0; irq = 0; exception = 0;
        branch_target = 0; jump_target = 0; jr_target = 0; exc_pc = 0;
    endtask

    task automatic model_reset();
        m_pc = R_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_epc = 0;
    endtask

    task automatic check_all(input string where);
        check({where, ".pc"},       pc,          m_pc);
        check({where, ".rom_addr"}, rom_addr,    {3'b000, m_pc[30:2]});
        check({where, ".instr"},    if_id_instr, m_instr);
        check({where, ".pc4"},      if_id_pc4,   m_pc4);
        check({where, ".valid"},    {31'd0, if_id_valid}, {31'd0, m_valid});
        check({where, ".epc"},      epc,         m_epc);
    endtask

    // Reference: apply one clock of the fetch rules to the model state.
    task automatic model_step();
        logic [31:0] npc;
        logic        bubble, load;
        bubble = 1'b1;
        load   = 1'b0;
        if (exception) begin
            npc = E_VEC; m_epc = exc_pc;
        end else if (irq && m_pc < 32'h8000_0000) begin
            npc = I_VEC; m_epc = m_pc;
        end else if (jr)           npc = jr_target;
        else if (jump)             npc = jump_target;
        else if (branch_taken)     npc = branch_target;
        else begin
            npc    = stall ? m_pc : m_pc + 4;
            bubble = flush;
            load   = !flush && !stall;
        end
        if (bubble) begin
            m_instr = 0; m_valid = 0;
        end else if (load) begin
            m_instr = rom_fn({3'b000, m_pc[30:2]});
            m_pc4   = m_pc + 4;
            m_valid = 1;
        end
        m_pc = npc;
    endtask

    task automatic cycle(input string where);
        model_step();
        @(posedge clk);
        #1;
        check_all(where);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic go_to(input logic [31:0] target);
        jump = 1; jump_target = target;
        cycle("goto");
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 0;

        repeat (3) cycle("freerun");

        stall = 1; cycle("stall1");
        stall = 1; cycle("stall2");
        cycle("resume");

        branch_taken = 1; branch_target = 32'h0000_0040;
        jump = 1; jump_target = 32'h0000_0080;
        cycle("jump_over_branch");
        cycle("after_jump");

        go_to(32'h0000_0054);
        irq = 1; cycle("irq_user");
        go_to(32'h8000_0010);
        irq = 1; cycle("irq_kernel");

        exception = 1; exc_pc = 32'h0000_0020; irq = 1; stall = 1;
        cycle("exc_prio");

        flush = 1; cycle("flush");
        flush = 1; stall = 1; cycle("flush_stall");
        jr = 1; jr_target = 32'h0000_1003; jump = 1; jump_target = 32'h0000_2000;
        cycle("jr_prio");

        go_to(32'hFFFF_FFFC);
        cycle("wrap");
        cycle("post_wrap");

        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom % 4) == 0;
            flush         = ($urandom % 6) == 0;
            branch_taken  = ($urandom % 8) == 0;
            jump          = ($urandom % 10) == 0;
            jr            = ($urandom % 12) == 0;
            irq           = ($urandom % 6) == 0;
            exception     = ($urandom % 16) == 0;
            branch_target = $urandom;
            jump_target   = $urandom;
            jr_target     = $urandom & 32'h7FFF_FFFF;
            exc_pc        = $urandom;
            cycle("random");
        end

        stall = 1;
        cycle("pre_reset");
        stall = 1;
        #2 reset = 1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 0;
        stall = 0;
        cycle("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
